// File: rtl/arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : arb_requester
// Description : Per-client FIFOs feeding an external one-hot round-robin
//               arbiter. Raises requests while the output register can take
//               an entry, pops the granted client's head into a registered
//               output slot, and flags malformed grants with a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_requester #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rstN,
  input  logic [NUM_PORTS-1:0]          push_i,
  input  logic [NUM_PORTS*DATA_W-1:0]   push_data_i,
  output logic [NUM_PORTS-1:0]          full_o,
  output logic [NUM_PORTS-1:0]          req_o,
  input  logic [NUM_PORTS-1:0]          gnt_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [$clog2(NUM_PORTS)-1:0]  out_port_o,
  output logic [DATA_W-1:0]             out_data_o,
  output logic                          err_o
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_CNT_W  = c_PTR_W + 1;
  localparam int c_PORT_W = $clog2(NUM_PORTS);

  logic                         w_slot_free;
  logic [NUM_PORTS-1:0]         w_push;
  logic [NUM_PORTS-1:0]         w_pop;
  logic [NUM_PORTS*DATA_W-1:0]  w_head_flat;
  logic                         w_gnt_onehot;
  logic                         w_gnt_hit;
  logic                         w_gnt_valid;
  logic                         w_gnt_err;
  logic [c_PORT_W-1:0]          w_gnt_idx;
  logic [DATA_W-1:0]            w_gnt_data;

  logic                         r_out_valid;
  logic [c_PORT_W-1:0]          r_out_port;
  logic [DATA_W-1:0]            r_out_data;
  logic                         r_err;

  // The output slot can take a new entry when empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready_i;

  // A grant is honoured only when it is exactly one bit and hits a live request.
  assign w_gnt_onehot = (gnt_i != '0) && ((gnt_i & (gnt_i - NUM_PORTS'(1))) == '0);
  assign w_gnt_hit    = |(gnt_i & req_o);
  assign w_gnt_valid  = w_gnt_onehot && w_gnt_hit;
  assign w_gnt_err    = (gnt_i != '0) && !w_gnt_valid;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [DATA_W-1:0]  r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_rptr;
      logic [c_PTR_W-1:0] r_wptr;
      logic [c_CNT_W-1:0] r_cnt;

      // full looks only at the registered count, so a same-cycle pop never frees room.
      assign full_o[p] = (r_cnt == c_CNT_W'(DEPTH));
      assign req_o[p]  = (r_cnt != '0) && w_slot_free;
      assign w_push[p] = push_i[p] && !full_o[p];
      assign w_pop[p]  = w_gnt_valid && gnt_i[p];
      assign w_head_flat[p*DATA_W +: DATA_W] = r_mem[r_rptr];

      // Payload storage; contents are don't-care until written, so no reset.
      always_ff @(posedge clk) begin
        if (w_push[p]) begin
          r_mem[r_wptr] <= push_data_i[p*DATA_W +: DATA_W];
        end
      end

      // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          r_rptr <= '0;
          r_wptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push[p]) r_wptr <= r_wptr + c_PTR_W'(1);
          if (w_pop[p])  r_rptr <= r_rptr + c_PTR_W'(1);
          case ({w_push[p], w_pop[p]})
            2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  // Encode the grant and select the matching head entry.
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_i[p]) begin
        w_gnt_idx  = c_PORT_W'(p);
        w_gnt_data = w_head_flat[p*DATA_W +: DATA_W];
      end
    end
  end

  // Output slot: load on a valid grant, otherwise empty once accepted.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_out_valid <= 1'b0;
      r_out_port  <= '0;
      r_out_data  <= '0;
    end else if (w_gnt_valid) begin
      r_out_valid <= 1'b1;
      r_out_port  <= w_gnt_idx;
      r_out_data  <= w_gnt_data;
    end else if (r_out_valid && out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky record of any malformed grant; only reset clears it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_err <= 1'b0;
    end else if (w_gnt_err) begin
      r_err <= 1'b1;
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_port_o  = r_out_port;
  assign out_data_o  = r_out_data;
  assign err_o       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_arb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_requester
// Description : Self-checking bench for arb_requester. A queue-per-client
//               reference model predicts requests, fullness, output slot and
//               error flag; a round-robin arbiter closes the grant loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_requester;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rstN = 1'b1;
  logic [NP-1:0]     push_i = '0;
  logic [NP*DW-1:0]  push_data_i = '0;
  logic [NP-1:0]     full_o;
  logic [NP-1:0]     req_o;
  logic [NP-1:0]     gnt_i;
  logic              out_valid_o;
  logic              out_ready_i = 1'b1;
  logic [1:0]        out_port_o;
  logic [DW-1:0]     out_data_o;
  logic              err_o;

  logic              arb_auto = 1'b0;
  logic [NP-1:0]     gnt_manual = '0;
  logic [NP-1:0]     gnt_auto;
  logic [1:0]        gnt_auto_idx;
  logic [1:0]        rr_last;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q [NP][$];
  logic          m_valid = 1'b0;
  logic [1:0]    m_port  = '0;
  logic [DW-1:0] m_data  = '0;
  logic          m_err   = 1'b0;

  arb_requester #(.NUM_PORTS(NP), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .push_i      (push_i),
    .push_data_i (push_data_i),
    .full_o      (full_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_port_o  (out_port_o),
    .out_data_o  (out_data_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter: search starts one past the last granted client.
  always_comb begin
    int idx;
    gnt_auto     = '0;
    gnt_auto_idx = '0;
    for (int o = 1; o <= NP; o++) begin
      idx = (int'(rr_last) + o) % NP;
      if (req_o[idx] && gnt_auto == '0) begin
        gnt_auto[idx] = 1'b1;
        gnt_auto_idx  = idx[1:0];
      end
    end
  end

  assign gnt_i = arb_auto ? gnt_auto : gnt_manual;

  // Arbiter pointer advances on every accepted grant.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) rr_last <= 2'd3;
    else if (arb_auto && gnt_auto != '0) rr_last <= gnt_auto_idx;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model across the edge, then check registered outputs.
  task automatic cycle(input logic [NP-1:0] push, input logic [NP*DW-1:0] data, input logic rdy);
    logic [NP-1:0] g, e_req, e_full, acc;
    logic          legal;
    int            k;
    push_i      = push;
    push_data_i = data;
    out_ready_i = rdy;
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      e_full[i] = (q[i].size() == DP);
      e_req[i]  = (q[i].size() != 0) && (!m_valid || rdy);
    end
    chk("req", 32'(req_o), 32'(e_req));
    chk("full", 32'(full_o), 32'(e_full));
    g     = gnt_i;
    legal = (g != '0) && ((g & (g - 4'd1)) == '0) && ((g & e_req) != '0);
    acc   = push & ~e_full;
    k = 0;
    for (int i = 0; i < NP; i++) if (g[i]) k = i;
    @(posedge clk);
    if (legal) begin
      m_data  = q[k].pop_front();
      m_port  = k[1:0];
      m_valid = 1'b1;
    end else begin
      if (m_valid && rdy) m_valid = 1'b0;
      if (g != '0) m_err = 1'b1;
    end
    for (int i = 0; i < NP; i++) if (acc[i]) q[i].push_back(data[i*DW +: DW]);
    #1;
    chk("out_valid", 32'(out_valid_o), 32'(m_valid));
    chk("out_port", 32'(out_port_o), 32'(m_port));
    chk("out_data", 32'(out_data_o), 32'(m_data));
    chk("err", 32'(err_o), 32'(m_err));
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic apply_reset();
    push_i      = '0;
    arb_auto    = 1'b0;
    gnt_manual  = '0;
    out_ready_i = 1'b1;
    rstN = 1'b0;
    #1;
    chk("rst_req", 32'(req_o), 32'h0);
    chk("rst_full", 32'(full_o), 32'h0);
    chk("rst_valid", 32'(out_valid_o), 32'h0);
    chk("rst_port", 32'(out_port_o), 32'h0);
    chk("rst_data", 32'(out_data_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    for (int i = 0; i < NP; i++) q[i].delete();
    m_valid = 1'b0; m_port = '0; m_data = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] held;
    #3;
    apply_reset();

    // Single push to client 2 flows through with one-cycle latencies.
    arb_auto = 1'b1;
    cycle(4'b0100, 32'h00A1_0000, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    chk("s1_port", 32'(out_port_o), 32'd2);
    chk("s1_data", 32'(out_data_o), 32'hA1);
    cycle(4'b0000, '0, 1'b1);

    // Fill client 0 while the arbiter idles; fifth push must be dropped.
    arb_auto = 1'b0; gnt_manual = '0;
    for (int j = 0; j < 4; j++) cycle(4'b0001, 32'(8'h10 + j), 1'b1);
    chk("s2_full", 32'(full_o[0]), 32'h1);
    cycle(4'b0001, 32'h14, 1'b1);
    arb_auto = 1'b1;
    for (int j = 0; j < 4; j++) begin
      cycle(4'b0000, '0, 1'b1);
      chk("s2_drain", 32'(out_data_o), 32'(8'h10 + j));
    end
    cycle(4'b0000, '0, 1'b1);
    chk("s2_req0", 32'(req_o[0]), 32'h0);

    // Round-robin from reset across all four clients.
    apply_reset();
    arb_auto = 1'b1;
    cycle(4'b1111, 32'h3322_1100, 1'b1);
    for (int j = 0; j < 4; j++) begin
      cycle(4'b0000, '0, 1'b1);
      chk("s3_rr", 32'(out_port_o), 32'(j));
    end
    cycle(4'b0000, '0, 1'b1);

    // Backpressure holds the slot and suppresses requests.
    cycle(4'b0011, 32'h0000_2120, 1'b1);
    cycle(4'b0011, 32'h0000_2322, 1'b0);
    held = out_data_o;
    for (int j = 0; j < 3; j++) begin
      cycle(4'b0000, '0, 1'b0);
      chk("s4_hold", 32'(out_data_o), 32'(held));
      chk("s4_noreq", 32'(req_o), 32'h0);
    end
    cycle(4'b0000, '0, 1'b1);
    repeat (4) cycle(4'b0000, '0, 1'b1);

    // Multi-bit grant is rejected and latches the error.
    apply_reset();
    cycle(4'b0011, 32'h0000_4140, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    gnt_manual = 4'b0011;
    cycle(4'b0000, '0, 1'b1);
    chk("s5_err", 32'(err_o), 32'h1);
    gnt_manual = '0;
    repeat (3) cycle(4'b0000, '0, 1'b1);
    chk("s5_req", 32'(req_o), 32'h3);

    // Reset mid-flight discards everything; fresh push behaves from empty.
    apply_reset();
    arb_auto = 1'b1;
    cycle(4'b0111, 32'h0062_6160, 1'b1);
    cycle(4'b0001, 32'h0000_0063, 1'b0);
    chk("s6_valid", 32'(out_valid_o), 32'h1);
    apply_reset();
    arb_auto = 1'b1;
    cycle(4'b0010, 32'h0000_5500, 1'b1);
    cycle(4'b0000, '0, 1'b1);
    chk("s6_data", 32'(out_data_o), 32'h55);
    chk("s6_port", 32'(out_port_o), 32'h1);

    // Randomized traffic with occasional idle (zero) grants.
    apply_reset();
    for (int j = 0; j < 400; j++) begin
      arb_auto   = ($urandom_range(0, 7) != 0);
      gnt_manual = '0;
      cycle(4'($urandom_range(0, 15)), 32'($urandom), ($urandom_range(0, 3) != 0));
    end
    arb_auto = 1'b1;
    repeat (20) cycle(4'b0000, '0, 1'b1);
    chk("final_req", 32'(req_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter NUM_PORTS, default 4, number of client ports and width of the req/gnt vectors.
REQ-002 Parameter DATA_W, default 8, payload width per entry.
REQ-003 Parameter DEPTH, default 4, entries per client FIFO; power of two, >= 2.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstN  input  1  asynchronous, active-low reset.
REQ-006 push_i  input  NUM_PORTS  per-client write strobe.
REQ-007 push_data_i  input  NUM_PORTS*DATA_W  per-client payload; client i occupies bits [i*DATA_W +: DATA_W].
REQ-008 full_o  output  NUM_PORTS  client FIFO i holds DEPTH entries.
REQ-009 req_o  output  NUM_PORTS  request vector to the round-robin arbiter.
REQ-010 gnt_i  input  NUM_PORTS  one-hot grant returned combinationally by the arbiter in the same cycle.
REQ-011 out_valid_o  output  1  output register holds a granted entry.
REQ-012 out_ready_i  input  1  downstream accepts the output entry this cycle.
REQ-013 out_port_o  output  $clog2(NUM_PORTS)  index of the client the output entry came from.
REQ-014 out_data_o  output  DATA_W  payload of the output entry.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Each client owns an independent DEPTH-entry FIFO with read pointer, write pointer and count of $clog2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-017 Push on client i SHALL be accepted iff push_i[i] && !full_o[i]; a push while full is dropped, with no state change on that FIFO and err_o unaffected.
REQ-018 full_o[i] SHALL be driven from registered count only (count == DEPTH); a pop in the same cycle does not make room for a push to a full FIFO.
REQ-019 Output slot free: slot_free = !out_valid_o || out_ready_i.
REQ-020 req_o[i] SHALL equal (count[i] != 0) && slot_free, combinational from registered state and out_ready_i only, never from gnt_i.
REQ-021 Entry accepted by push at edge N SHALL first raise req_o at cycle N+1 (one-cycle push-to-request latency).
REQ-022 Valid grant: gnt_i one-hot and gnt_i & req_o nonzero; at that edge the head of client k pops, out_data_o/out_port_o load head data and k, out_valid_o = 1.
REQ-023 Grant-to-output latency SHALL be one cycle; back-to-back grants every cycle SHALL sustain one entry per cycle while out_ready_i is held 1.
REQ-024 Push and pop on the same non-full client in one cycle SHALL both occur; count unchanged, FIFO order preserved.
REQ-025 If no valid grant and out_valid_o && out_ready_i, out_valid_o SHALL clear; out_data_o/out_port_o hold their last values.
REQ-026 If out_valid_o && !out_ready_i, the output register SHALL hold stable and req_o SHALL be all zero.
REQ-027 gnt_i with more than one bit set, or a set bit where req_o is 0, SHALL cause no pop and no output change and SHALL set err_o; err_o clears only on reset.
REQ-028 gnt_i == 0 with req_o nonzero is legal: no pop, no error.
REQ-029 Per-client FIFO order SHALL be strictly preserved; no entry is duplicated or lost except dropped full pushes.

Reset
REQ-030 rstN low SHALL immediately clear all counts and pointers, out_valid_o, err_o, out_port_o and out_data_o to 0; full_o and req_o read 0.
REQ-031 Reset asserted mid-operation SHALL discard all queued and in-flight entries; first push after release behaves as from empty.
REQ-032 Release of rstN is assumed synchronous to clk externally; no internal synchronizer.

Verification
REQ-033 Push 0xA1 to client 2 at edge 0, out_ready_i = 1, arbiter attached -> req_o = 4'b0100 at cycle 1, out_valid_o = 1, out_port_o = 2, out_data_o = 0xA1 at cycle 2.
REQ-034 Fill client 0 with 0x10..0x13, push 0x14 -> full_o[0] = 1, 0x14 dropped; drain yields 0x10,0x11,0x12,0x13 in order, then req_o[0] = 0.
REQ-035 One entry on each of clients 0..3, out_ready_i = 1, round-robin arbiter from reset -> out_port_o sequence 0,1,2,3 on four consecutive cycles.
REQ-036 out_valid_o = 1, out_ready_i = 0 for 3 cycles with clients nonempty -> req_o = 0, output stable for 3 cycles; out_ready_i = 1 -> next grant loads next cycle.
REQ-037 Drive gnt_i = 4'b0011 with req_o = 4'b0011 -> no pop, counts unchanged, err_o = 1 and held until rstN low.
REQ-038 Assert rstN low with 3 entries queued and out_valid_o = 1 -> all outputs 0 immediately without a clock edge; after release, push 0x55 to client 1 -> out_data_o = 0x55 two cycles later.
